// File: rtl/systolic_ctrl_if.sv
// Control bundle between the host, the systolic sequencer and the array/operand buffers.
// The host side drives start/k_len; the sequencer drives everything else.
interface systolic_ctrl_if #(
    parameter int N       = 4,
    parameter int K_WIDTH = 8
);
    logic                   start;
    logic [K_WIDTH-1:0]     k_len;
    logic                   busy;
    logic                   done;
    logic                   result_capture;
    logic                   pe_clear;
    logic [N-1:0]           feed_valid;
    logic [N*K_WIDTH-1:0]   feed_idx;

    modport master (
        output start, k_len,
        input  busy, done, result_capture, pe_clear, feed_valid, feed_idx
    );

    modport slave (
        input  start, k_len,
        output busy, done, result_capture, pe_clear, feed_valid, feed_idx
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clear, skewed operand feed,
// wavefront drain, then a one-cycle done/result_capture pulse. Control only, no datapath.
module systolic_ctrl #(
    parameter int N       = 4,
    parameter int K_WIDTH = 8,
    parameter int RD_LAT  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    systolic_ctrl_if.slave  ctrl
);
    localparam int TW           = K_WIDTH + $clog2(N) + 1;
    localparam int DRAIN_CYCLES = N - 1 + RD_LAT;
    localparam int DW           = $clog2(N + RD_LAT + 1) + 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // With a single lane and no read latency there is nothing left to drain.
    localparam state_t AFTER_FEED = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;

    state_t             state_r, state_s;
    logic [TW-1:0]      t_r, t_s;
    logic [DW-1:0]      d_r, d_s;
    logic [K_WIDTH-1:0] klen_r, klen_s;
    logic [TW-1:0]      feed_last_s;

    logic               busy_s, done_s, pe_clear_s;
    logic [N-1:0]       feed_valid_s;
    logic [N*K_WIDTH-1:0] feed_idx_s;
    logic               busy_r, done_r, pe_clear_r;
    logic [N-1:0]       feed_valid_r;
    logic [N*K_WIDTH-1:0] feed_idx_r;

    assign feed_last_s = TW'(klen_r) + TW'(N) - TW'(2);

    // State, counters and latched inner dimension
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            t_r     <= {TW{1'b0}};
            d_r     <= {DW{1'b0}};
            klen_r  <= {K_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            t_r     <= t_s;
            d_r     <= d_s;
            klen_r  <= klen_s;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_s = state_r;
        t_s     = t_r;
        d_s     = d_r;
        klen_s  = klen_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (ctrl.start) begin
                    klen_s  = ctrl.k_len;
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                t_s = {TW{1'b0}};
                d_s = {DW{1'b0}};
                if (klen_r == {K_WIDTH{1'b0}}) begin
                    state_s = AFTER_FEED;
                end else begin
                    state_s = ST_FEED;
                end
            end
            ST_FEED: begin
                if (t_r == feed_last_s) begin
                    t_s     = {TW{1'b0}};
                    state_s = AFTER_FEED;
                end else begin
                    t_s = t_r + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (d_r == DRAIN_LAST) begin
                    d_s     = {DW{1'b0}};
                    state_s = ST_DONE;
                end else begin
                    d_s = d_r + DW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                t_s     = {TW{1'b0}};
                d_s     = {DW{1'b0}};
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        busy_s       = (state_s == ST_CLEAR) || (state_s == ST_FEED) || (state_s == ST_DRAIN);
        done_s       = (state_s == ST_DONE);
        pe_clear_s   = (state_s == ST_CLEAR);
        feed_valid_s = {N{1'b0}};
        feed_idx_s   = {(N*K_WIDTH){1'b0}};
        for (int i = 0; i < N; i++) begin
            if ((state_s == ST_FEED) && (t_s >= TW'(i)) && (t_s < TW'(i) + TW'(klen_s))) begin
                feed_valid_s[i]                    = 1'b1;
                feed_idx_s[i*K_WIDTH +: K_WIDTH]   = K_WIDTH'(t_s - TW'(i));
            end else begin
                feed_valid_s[i]                    = 1'b0;
                feed_idx_s[i*K_WIDTH +: K_WIDTH]   = {K_WIDTH{1'b0}};
            end
        end
    end

    // Output registers; PEs are held in clear throughout system reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pe_clear_r   <= 1'b1;
            feed_valid_r <= {N{1'b0}};
            feed_idx_r   <= {(N*K_WIDTH){1'b0}};
        end else begin
            busy_r       <= busy_s;
            done_r       <= done_s;
            pe_clear_r   <= pe_clear_s;
            feed_valid_r <= feed_valid_s;
            feed_idx_r   <= feed_idx_s;
        end
    end

    assign ctrl.busy           = busy_r;
    assign ctrl.done           = done_r;
    assign ctrl.result_capture = done_r;
    assign ctrl.pe_clear       = pe_clear_r;
    assign ctrl.feed_valid     = feed_valid_r;
    assign ctrl.feed_idx       = feed_idx_r;
endmodule
